sweep_sched: RTL and testbench

- Frequency-sweep scheduler for the DDS sine path: phase-increment adder, address register, sine ROM, then SPI DAC and PWM outputs.
- Generates the 10-bit phase increment that would otherwise come straight from SW.
- Steps the increment from a start word to an end word, holding each word for a programmable number of sample ticks. All updates are aligned to the sample strobe.
- Sits between the switch/config logic and the phase-increment adder; sample strobe comes from the 5k clock divider.

---
 rtl/sweep_sched.sv | 148 ++++++++++++++
 tb/tb_sweep_sched.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sweep_sched.sv
// rtl/sweep_sched.sv - tick-aligned frequency sweep generator for the DDS phase increment
module sweep_sched #(
  parameter int W    = 10,
  parameter int DW   = 16,
  parameter int LOOP = 0
) (
  input  logic          CLOCK_50,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          start,
  input  logic          stop,
  input  logic [W-1:0]  f_start,
  input  logic [W-1:0]  f_end,
  input  logic [W-1:0]  step,
  input  logic [DW-1:0] dwell,
  output logic [W-1:0]  incr,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_STEP} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  incr_q, incr_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  start_q, start_d;
  logic [W-1:0]  end_q, end_d;
  logic [W-1:0]  step_q, step_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          up_q, up_d;
  logic          final_q, final_d;
  logic          done_q, done_d;

  logic [W:0]    sum;
  logic [W:0]    diff;
  logic [DW-1:0] last_cnt;
  logic          up_clamp;
  logic          dn_clamp;

  // W+1 bit arithmetic exposes carry/borrow so the clamp never wraps.
  assign sum      = {1'b0, incr_q} + {1'b0, step_q};
  assign diff     = {1'b0, incr_q} - {1'b0, step_q};
  assign last_cnt = (dwell_q == '0) ? '0 : dwell_q - DW'(1);
  assign up_clamp = (sum >= {1'b0, end_q}) || (step_q == '0);
  assign dn_clamp = diff[W] || (diff[W-1:0] <= end_q) || (step_q == '0);

  always_comb begin
    state_d = state_q;
    incr_d  = incr_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    end_d   = end_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    up_d    = up_q;
    final_d = final_q;
    done_d  = 1'b0;

    if (stop) begin
      state_d = S_IDLE;
      incr_d  = '0;
      cnt_d   = '0;
      final_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          incr_d = '0;
          if (start) begin
            state_d = S_HOLD;
            start_d = f_start;
            end_d   = f_end;
            step_d  = step;
            dwell_d = dwell;
            up_d    = (f_end >= f_start);
            final_d = (f_end == f_start);
            incr_d  = f_start;
            cnt_d   = '0;
          end
        end
        S_HOLD: begin
          if (tick) begin
            if (cnt_q == last_cnt) begin
              cnt_d = '0;
              if (!final_q) begin
                state_d = S_STEP;
              end else if (LOOP != 0) begin
                incr_d  = start_q;
                final_d = (start_q == end_q);
              end else begin
                state_d = S_IDLE;
                incr_d  = '0;
                final_d = 1'b0;
                done_d  = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + DW'(1);
            end
          end
        end
        S_STEP: begin
          state_d = S_HOLD;
          cnt_d   = '0;
          if (up_q ? up_clamp : dn_clamp) begin
            incr_d  = end_q;
            final_d = 1'b1;
          end else begin
            incr_d  = up_q ? sum[W-1:0] : diff[W-1:0];
          end
        end
        default: begin
          state_d = S_IDLE;
          incr_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      incr_q  <= '0;
      cnt_q   <= '0;
      start_q <= '0;
      end_q   <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      up_q    <= 1'b0;
      final_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      incr_q  <= incr_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      end_q   <= end_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      up_q    <= up_d;
      final_q <= final_d;
      done_q  <= done_d;
    end
  end

  assign incr = incr_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_sweep_sched.sv
// tb/tb_sweep_sched.sv - randomized and directed checks of sweep_sched against a word-list model
module tb_sweep_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        start_l = 1'b0;
  logic        stop = 1'b0;
  logic [9:0]  f_start = '0;
  logic [9:0]  f_end = '0;
  logic [9:0]  step = '0;
  logic [15:0] dwell = '0;
  logic [9:0]  incr, incr_l;
  logic        busy, busy_l, done, done_l;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int done_l_cnt = 0;
  int exp_q[$];

  sweep_sched #(.W(10), .DW(16), .LOOP(0)) dut (
    .CLOCK_50(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop),
    .f_start(f_start), .f_end(f_end), .step(step), .dwell(dwell),
    .incr(incr), .busy(busy), .done(done)
  );

  sweep_sched #(.W(10), .DW(16), .LOOP(1)) dut_l (
    .CLOCK_50(clk), .rst_n(rst_n), .tick(tick), .start(start_l), .stop(stop),
    .f_start(f_start), .f_end(f_end), .step(step), .dwell(dwell),
    .incr(incr_l), .busy(busy_l), .done(done_l)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (done_l) done_l_cnt++;
    if (done || done_l) begin
      checks++;
      assert (!(done && busy) && !(done_l && busy_l))
      else begin
        failures++;
        $error("FAIL done_with_busy observed=%0d expected=0", (done && busy) || (done_l && busy_l));
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: list of words the sweep visits, derived with plain integer arithmetic.
  task automatic build(input int fs, input int fe, input int st);
    int  cur;
    bit  fin;
    exp_q.delete();
    cur = fs;
    exp_q.push_back(cur);
    fin = (fs == fe);
    while (!fin) begin
      if (fe >= fs) begin
        if (st == 0 || cur + st >= fe) begin cur = fe; fin = 1; end
        else cur = cur + st;
      end else begin
        if (st == 0 || cur - st <= fe) begin cur = fe; fin = 1; end
        else cur = cur - st;
      end
      exp_q.push_back(cur);
    end
  endtask

  task automatic pulse_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic scramble();
    f_start = 10'($urandom);
    f_end   = 10'($urandom);
    step    = 10'($urandom);
    dwell   = 16'($urandom);
  endtask

  task automatic launch(input int fs, input int fe, input int st, input int dw);
    @(negedge clk);
    f_start = 10'(fs); f_end = 10'(fe); step = 10'(st); dwell = 16'(dw);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_sweep(input int fs, input int fe, input int st, input int dw);
    int d, n, d0;
    build(fs, fe, st);
    d  = (dw == 0) ? 1 : dw;
    n  = exp_q.size() * d;
    d0 = done_cnt;
    launch(fs, fe, st, dw);
    for (int i = 0; i < n; i++) begin
      repeat (2) @(negedge clk);
      chk($sformatf("incr[%0d]", i), {22'b0, incr}, exp_q[i / d]);
      chk("busy_run", {31'b0, busy}, 1);
      scramble();
      pulse_tick();
    end
    chk("done_pulse", {31'b0, done}, 1);
    repeat (3) @(negedge clk);
    chk("done_count", done_cnt, d0 + 1);
    chk("incr_end", {22'b0, incr}, 0);
    chk("busy_end", {31'b0, busy}, 0);
  endtask

  initial begin
    int d0;
    #2;
    chk("rst_incr", {22'b0, incr}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_sweep(10, 40, 10, 3);
    run_sweep(100, 5, 40, 1);
    run_sweep(7, 50, 0, 0);
    run_sweep(33, 33, 5, 2);

    // Abort during HOLD at incr=20.
    d0 = done_cnt;
    launch(10, 40, 10, 3);
    repeat (3) pulse_tick();
    repeat (3) @(negedge clk);
    chk("abort_pre", {22'b0, incr}, 20);
    stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    chk("abort_incr", {22'b0, incr}, 0);
    chk("abort_busy", {31'b0, busy}, 0);

    // start and stop together while idle.
    @(negedge clk);
    f_start = 10'd9; f_end = 10'd90; step = 10'd9; dwell = 16'd1;
    start = 1'b1; stop = 1'b1;
    @(negedge clk) begin start = 1'b0; stop = 1'b0; end
    chk("ss_busy", {31'b0, busy}, 0);
    chk("ss_incr", {22'b0, incr}, 0);
    repeat (3) @(negedge clk);
    chk("abort_nodone", done_cnt, d0);

    // LOOP=1: cyclic 1,2,3 with a stray start mid-sweep.
    @(negedge clk);
    f_start = 10'd1; f_end = 10'd3; step = 10'd1; dwell = 16'd1;
    start_l = 1'b1;
    @(negedge clk) start_l = 1'b0;
    for (int i = 0; i < 10; i++) begin
      repeat (2) @(negedge clk);
      chk($sformatf("loop[%0d]", i), {22'b0, incr_l}, 32'(1 + (i % 3)));
      chk("loop_busy", {31'b0, busy_l}, 1);
      if (i == 4) begin
        f_start = 10'd200; f_end = 10'd300;
        start_l = 1'b1;
        @(negedge clk) start_l = 1'b0;
      end
      pulse_tick();
    end
    chk("loop_nodone", done_l_cnt, 0);
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    chk("loop_stop", {31'b0, busy_l}, 0);

    // Asynchronous reset between edges mid-sweep.
    d0 = done_cnt;
    launch(10, 40, 10, 1);
    repeat (2) pulse_tick();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_incr", {22'b0, incr}, 0);
    chk("arst_busy", {31'b0, busy}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_nodone", done_cnt, d0);

    for (int r = 0; r < 20; r++) begin
      int fs, fe, st, dw;
      fs = $urandom_range(0, 1023);
      fe = $urandom_range(0, 1023);
      st = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(64, 1023);
      dw = $urandom_range(0, 3);
      run_sweep(fs, fe, st, dw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
